mouse_cell_editor: RTL and testbench

- Converts PS/2 mouse movement packets into a clamped on-screen cursor position, at 1 cell = 4x4 pixels.
- Turns button presses into read-modify-write edits of the 32 x 40-bit Life grid row memory.
- Works in the opposite direction to the grid renderer. The renderer maps cell to pixel; this block maps pixel to cell and writes cells back.
- Its x_mouse/y_mouse outputs feed the renderer's cursor overlay. Its row port shares the grid memory with the simulation engine through an external arbiter.

---
 rtl/mouse_cell_editor.sv | 152 +++++++++++++++
 tb/tb_mouse_cell_editor.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_cell_editor.sv
// Mouse-driven Life grid editor: integrates PS/2 movement into a clamped pixel
// cursor and applies button presses as read-modify-write edits of grid rows.
//
// state   | meaning
// --------+------------------------------------------------------
// S_IDLE  | waiting for a button press edge on a mouse packet
// S_READ  | row read request issued for the latched row
// S_WAIT  | row word returns; modified word is captured
// S_WRITE | modified row word written back
// S_DONE  | edit_done pulse, last busy cycle
module mouse_cell_editor #(
   parameter int COLS       = 40,
   parameter int ROWS       = 32,
   parameter int CELL_SHIFT = 2,
   parameter int SCREEN_W   = 160,
   parameter int SCREEN_H   = 120
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mouse_valid,
   input  logic [8:0]               dx,
   input  logic [8:0]               dy,
   input  logic                     btn_left,
   input  logic                     btn_right,
   output logic [9:0]               x_mouse,
   output logic [9:0]               y_mouse,
   output logic                     row_rd_en,
   output logic [$clog2(ROWS)-1:0]  row_addr,
   input  logic [COLS-1:0]          row_rd_data,
   output logic                     row_wr_en,
   output logic [COLS-1:0]          row_wr_data,
   output logic                     busy,
   output logic                     edit_done
);

   localparam int AW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam logic [COLS-1:0] COL0_MASK = {1'b1, {(COLS-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [9:0]        x_q, x_d;
   logic [9:0]        y_q, y_d;
   logic              prev_l_q, prev_l_d;
   logic              prev_r_q, prev_r_d;
   logic [CW-1:0]     col_q, col_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic              clr_q, clr_d;
   logic [COLS-1:0]   wr_data_q, wr_data_d;

   logic [10:0]       nx, ny;
   logic [9:0]        nx_c, ny_c;
   logic              press_l, press_r;
   logic [COLS-1:0]   col_mask;

   always_comb begin
      // movement fits comfortably in 11 bits, so bit 10 is the sign
      nx = {1'b0, x_q} + {{2{dx[8]}}, dx};
      ny = {1'b0, y_q} - {{2{dy[8]}}, dy};

      if (nx[10])                          nx_c = '0;
      else if (nx > 11'(SCREEN_W - 1))     nx_c = 10'(SCREEN_W - 1);
      else                                 nx_c = nx[9:0];

      if (ny[10])                          ny_c = '0;
      else if (ny > 11'(SCREEN_H - 1))     ny_c = 10'(SCREEN_H - 1);
      else                                 ny_c = ny[9:0];

      press_l  = btn_left  & ~prev_l_q;
      press_r  = btn_right & ~prev_r_q;
      col_mask = COL0_MASK >> col_q;
   end

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      prev_l_d  = prev_l_q;
      prev_r_d  = prev_r_q;
      col_d     = col_q;
      addr_d    = addr_q;
      clr_d     = clr_q;
      wr_data_d = wr_data_q;

      if (mouse_valid) begin
         x_d      = nx_c;
         y_d      = ny_c;
         prev_l_d = btn_left;
         prev_r_d = btn_right;
      end

      case (state_q)
         S_IDLE: begin
            if (mouse_valid && (press_l || press_r)) begin
               state_d = S_READ;
               col_d   = nx_c[CELL_SHIFT +: CW];
               addr_d  = ny_c[CELL_SHIFT +: AW];
               clr_d   = press_r;
            end
         end
         S_READ:  state_d = S_WAIT;
         S_WAIT: begin
            state_d   = S_WRITE;
            wr_data_d = clr_q ? (row_rd_data & ~col_mask) : (row_rd_data ^ col_mask);
         end
         S_WRITE: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         x_q       <= 10'(SCREEN_W / 2);
         y_q       <= 10'(SCREEN_H / 2);
         prev_l_q  <= 1'b0;
         prev_r_q  <= 1'b0;
         col_q     <= '0;
         addr_q    <= '0;
         clr_q     <= 1'b0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         prev_l_q  <= prev_l_d;
         prev_r_q  <= prev_r_d;
         col_q     <= col_d;
         addr_q    <= addr_d;
         clr_q     <= clr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign x_mouse     = x_q;
   assign y_mouse     = y_q;
   assign row_addr    = addr_q;
   assign row_wr_data = wr_data_q;
   assign row_rd_en   = (state_q == S_READ);
   assign row_wr_en   = (state_q == S_WRITE);
   assign edit_done   = (state_q == S_DONE);
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mouse_cell_editor.sv
// Bench for mouse_cell_editor: grid memory model plus an integer cursor/edit
// reference model driven by directed and random mouse packets.
module tb_mouse_cell_editor;

   logic        clk = 1'b0;
   logic        reset;
   logic        mouse_valid;
   logic [8:0]  dx, dy;
   logic        btn_left, btn_right;
   logic [9:0]  x_mouse, y_mouse;
   logic        row_rd_en;
   logic [4:0]  row_addr;
   logic [39:0] row_rd_data;
   logic        row_wr_en;
   logic [39:0] row_wr_data;
   logic        busy, edit_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mouse_cell_editor dut (
      .clk(clk), .reset(reset), .mouse_valid(mouse_valid), .dx(dx), .dy(dy),
      .btn_left(btn_left), .btn_right(btn_right), .x_mouse(x_mouse), .y_mouse(y_mouse),
      .row_rd_en(row_rd_en), .row_addr(row_addr), .row_rd_data(row_rd_data),
      .row_wr_en(row_wr_en), .row_wr_data(row_wr_data), .busy(busy), .edit_done(edit_done)
   );

   // grid memory shared with the DUT, plus a preload port for the bench
   logic [39:0] mem [32];
   logic        pre_en = 1'b0;
   logic [4:0]  pre_addr = '0;
   logic [39:0] pre_data = '0;

   always @(posedge clk) begin
      if (row_rd_en) row_rd_data <= mem[row_addr];
      if (row_wr_en) mem[row_addr] <= row_wr_data;
      if (pre_en)    mem[pre_addr] <= pre_data;
   end

   // reference model
   logic [39:0] ref_grid [32];
   int   rx, ry;
   logic m_pl, m_pr;
   logic m_idle = 1'b1;
   logic m_req, e_clr;
   int   e_row, e_col;

   typedef struct {
      logic [8:0] dx;
      logic [8:0] dy;
      logic       l;
      logic       r;
   } pkt_t;
   pkt_t pq [$];

   function automatic logic [39:0] apply(input logic [39:0] w, input int col, input logic clr);
      logic [39:0] res;
      res = w;
      if (clr) res[39-col] = 1'b0;
      else     res[39-col] = ~res[39-col];
      return res;
   endfunction

   task automatic preload(input int a, input logic [39:0] d);
      pre_addr = 5'(a);
      pre_data = d;
      pre_en   = 1'b1;
      ref_grid[a] = d;
      @(posedge clk);
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   // drive one packet during the current cycle and advance the model; returns
   // on the negedge of the cycle after the packet edge
   task automatic pkt(input logic [8:0] pdx, input logic [8:0] pdy, input logic pl, input logic pr);
      int nx, ny;
      logic p_l, p_r;
      nx = rx + int'($signed(pdx));
      ny = ry - int'($signed(pdy));
      if (nx < 0) nx = 0;
      if (nx > 159) nx = 159;
      if (ny < 0) ny = 0;
      if (ny > 119) ny = 119;
      p_l = pl && !m_pl;
      p_r = pr && !m_pr;
      m_req = m_idle && (p_l || p_r);
      if (m_req) begin
         e_col = nx / 4;
         e_row = ny / 4;
         e_clr = p_r;
      end
      m_pl = pl;
      m_pr = pr;
      rx = nx;
      ry = ny;
      dx = pdx; dy = pdy; btn_left = pl; btn_right = pr;
      mouse_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mouse_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; mouse_valid = 1'b0; dx = '0; dy = '0; btn_left = 1'b0; btn_right = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      rx = 80; ry = 60; m_pl = 1'b0; m_pr = 1'b0;
      checks++;
      if (x_mouse !== 10'd80 || y_mouse !== 10'd60) begin
         errors++; $display("FAIL reset_cursor: got (%0d,%0d) want (80,60)", x_mouse, y_mouse);
      end
      checks++;
      if ({row_rd_en, row_wr_en, busy, edit_done} !== 4'b0000 || row_addr !== 5'd0 || row_wr_data !== 40'd0) begin
         errors++; $display("FAIL reset_outputs: rd=%b wr=%b busy=%b done=%b addr=%0d wdata=%h want all 0",
                            row_rd_en, row_wr_en, busy, edit_done, row_addr, row_wr_data);
      end
   endtask

   task automatic test_clamp();
      pkt(9'd200, 9'd100, 1'b0, 1'b0);
      checks++;
      if (x_mouse !== 10'd159 || y_mouse !== 10'd0) begin
         errors++; $display("FAIL clamp_max: got (%0d,%0d) want (159,0)", x_mouse, y_mouse);
      end
      pkt(9'h100, 9'h138, 1'b0, 1'b0);
      checks++;
      if (x_mouse !== 10'd0 || y_mouse !== 10'd119) begin
         errors++; $display("FAIL clamp_min: got (%0d,%0d) want (0,119)", x_mouse, y_mouse);
      end
      checks++;
      if (x_mouse !== 10'(rx) || y_mouse !== 10'(ry) || busy !== 1'b0) begin
         errors++; $display("FAIL clamp_model: got (%0d,%0d) busy=%b want (%0d,%0d) busy=0",
                            x_mouse, y_mouse, busy, rx, ry);
      end
   endtask

   // runs the queued packets then n_rand random ones, checking each edit cycle
   task automatic test_edit_sequence(input int n_rand);
      pkt_t p;
      logic [39:0] w;
      int total;
      total = pq.size() + n_rand;
      for (int i = 0; i < total; i++) begin
         if (i < pq.size()) p = pq[i];
         else begin
            p.dx = 9'($urandom_range(0, 511));
            p.dy = 9'($urandom_range(0, 511));
            p.l  = 1'($urandom_range(0, 1));
            p.r  = ($urandom_range(0, 3) == 0);
         end
         pkt(p.dx, p.dy, p.l, p.r);
         checks++;
         if (x_mouse !== 10'(rx) || y_mouse !== 10'(ry)) begin
            errors++; $display("FAIL seq_cursor[%0d]: got (%0d,%0d) want (%0d,%0d)", i, x_mouse, y_mouse, rx, ry);
         end
         if (m_req) begin
            w = apply(ref_grid[e_row], e_col, e_clr);
            checks++;
            if ({row_rd_en, row_wr_en, busy, edit_done} !== 4'b1010 || row_addr !== 5'(e_row)) begin
               errors++; $display("FAIL seq_read[%0d]: rd/wr/busy/done=%b%b%b%b addr=%0d want 1010 addr=%0d",
                                  i, row_rd_en, row_wr_en, busy, edit_done, row_addr, e_row);
            end
            @(negedge clk);
            checks++;
            if ({row_rd_en, row_wr_en, busy, edit_done} !== 4'b0010) begin
               errors++; $display("FAIL seq_wait[%0d]: rd/wr/busy/done=%b%b%b%b want 0010",
                                  i, row_rd_en, row_wr_en, busy, edit_done);
            end
            @(negedge clk);
            checks++;
            if ({row_rd_en, row_wr_en, busy, edit_done} !== 4'b0110 || row_addr !== 5'(e_row) || row_wr_data !== w) begin
               errors++; $display("FAIL seq_write[%0d]: rd/wr/busy/done=%b%b%b%b addr=%0d data=%h want 0110 addr=%0d data=%h",
                                  i, row_rd_en, row_wr_en, busy, edit_done, row_addr, row_wr_data, e_row, w);
            end
            @(negedge clk);
            checks++;
            if ({row_rd_en, row_wr_en, busy, edit_done} !== 4'b0011) begin
               errors++; $display("FAIL seq_done[%0d]: rd/wr/busy/done=%b%b%b%b want 0011",
                                  i, row_rd_en, row_wr_en, busy, edit_done);
            end
            @(negedge clk);
            checks++;
            if ({row_rd_en, row_wr_en, busy, edit_done} !== 4'b0000) begin
               errors++; $display("FAIL seq_idle[%0d]: rd/wr/busy/done=%b%b%b%b want 0000",
                                  i, row_rd_en, row_wr_en, busy, edit_done);
            end
            ref_grid[e_row] = w;
         end else begin
            checks++;
            if ({row_rd_en, row_wr_en, busy, edit_done} !== 4'b0000) begin
               errors++; $display("FAIL seq_no_req[%0d]: rd/wr/busy/done=%b%b%b%b want 0000",
                                  i, row_rd_en, row_wr_en, busy, edit_done);
            end
         end
      end
      pq.delete();
   endtask

   task automatic test_toggle();
      pkt(9'd13, 9'd110, 1'b0, 1'b0);
      checks++;
      if (x_mouse !== 10'd13 || y_mouse !== 10'd9) begin
         errors++; $display("FAIL toggle_pos: got (%0d,%0d) want (13,9)", x_mouse, y_mouse);
      end
      preload(2, 40'h00_0000_0000);
      pq.push_back('{9'd0, 9'd0, 1'b1, 1'b0});
      pq.push_back('{9'd0, 9'd0, 1'b0, 1'b0});
      test_edit_sequence(0);
      checks++;
      if (mem[2] !== 40'h10_0000_0000) begin
         errors++; $display("FAIL toggle_set: row2=%h want 1000000000", mem[2]);
      end
      pq.push_back('{9'd0, 9'd0, 1'b1, 1'b0});
      pq.push_back('{9'd0, 9'd0, 1'b0, 1'b0});
      test_edit_sequence(0);
      checks++;
      if (mem[2] !== 40'h00_0000_0000) begin
         errors++; $display("FAIL toggle_back: row2=%h want 0000000000", mem[2]);
      end
   endtask

   task automatic test_priority();
      preload(2, 40'hFF_FFFF_FFFF);
      pq.push_back('{9'd0, 9'd0, 1'b1, 1'b1});
      pq.push_back('{9'd0, 9'd0, 1'b1, 1'b1});
      pq.push_back('{9'd0, 9'd0, 1'b0, 1'b0});
      test_edit_sequence(0);
      checks++;
      if (mem[2] !== 40'hEF_FFFF_FFFF) begin
         errors++; $display("FAIL priority_clear: row2=%h want efffffffff", mem[2]);
      end
   endtask

   task automatic test_busy_drop();
      logic [39:0] w;
      int n_rd, n_wr, n_done;
      preload(2, 40'h00_0000_0000);
      pkt(9'd0, 9'd0, 1'b1, 1'b0);
      w = apply(ref_grid[e_row], e_col, e_clr);
      m_idle = 1'b0;
      pkt(9'd4, 9'd0, 1'b0, 1'b1);
      m_idle = 1'b1;
      checks++;
      if (x_mouse !== 10'd17 || x_mouse !== 10'(rx)) begin
         errors++; $display("FAIL busy_cursor: x=%0d want 17", x_mouse);
      end
      n_rd = 0; n_wr = 0; n_done = 0;
      for (int i = 0; i < 6; i++) begin
         n_rd   += int'(row_rd_en);
         n_wr   += int'(row_wr_en);
         n_done += int'(edit_done);
         @(negedge clk);
      end
      checks++;
      if (n_rd != 0 || n_wr != 1 || n_done != 1) begin
         errors++; $display("FAIL busy_drop: reads=%0d writes=%0d dones=%0d want 0,1,1", n_rd, n_wr, n_done);
      end
      checks++;
      if (mem[2] !== w) begin
         errors++; $display("FAIL busy_edit: row2=%h want %h", mem[2], w);
      end
      ref_grid[2] = w;
      pkt(9'd0, 9'd0, 1'b0, 1'b0);
      pkt(9'd0, 9'd0, 1'b0, 1'b1);
      checks++;
      if (m_req !== 1'b1 || row_rd_en !== 1'b1 || row_addr !== 5'd2) begin
         errors++; $display("FAIL busy_later_press: rd=%b addr=%0d want rd=1 addr=2", row_rd_en, row_addr);
      end
      w = apply(ref_grid[e_row], e_col, e_clr);
      repeat (4) @(negedge clk);
      checks++;
      if (mem[2] !== w || busy !== 1'b0) begin
         errors++; $display("FAIL busy_later_edit: row2=%h busy=%b want %h busy=0", mem[2], busy, w);
      end
      ref_grid[2] = w;
      pkt(9'd0, 9'd0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic [63:0] t;
      for (int r = 0; r < 32; r++) begin
         t = {$urandom(), $urandom()};
         preload(r, t[39:0]);
      end
      test_edit_sequence(80);
   endtask

   task automatic test_reset_mid_edit();
      int n_wr, row;
      logic [39:0] w;
      pkt(9'd0, 9'd0, 1'b0, 1'b0);
      pkt(9'd0, 9'd0, 1'b1, 1'b0);
      row = e_row;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || m_req !== 1'b1) begin
         errors++; $display("FAIL rst_mid_setup: busy=%b want 1", busy);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      rx = 80; ry = 60; m_pl = 1'b0; m_pr = 1'b0;
      n_wr = 0;
      for (int i = 0; i < 8; i++) begin
         n_wr += int'(row_wr_en);
         @(negedge clk);
      end
      checks++;
      if (n_wr != 0 || mem[row] !== ref_grid[row]) begin
         errors++; $display("FAIL rst_mid_nowrite: writes=%0d row=%h want 0 writes row=%h", n_wr, mem[row], ref_grid[row]);
      end
      checks++;
      if (x_mouse !== 10'd80 || y_mouse !== 10'd60 || {row_rd_en, row_wr_en, busy, edit_done} !== 4'b0000 ||
          row_addr !== 5'd0 || row_wr_data !== 40'd0) begin
         errors++; $display("FAIL rst_mid_outputs: (%0d,%0d) rd/wr/busy/done=%b%b%b%b addr=%0d wdata=%h want reset values",
                            x_mouse, y_mouse, row_rd_en, row_wr_en, busy, edit_done, row_addr, row_wr_data);
      end
      // left is still held from before reset, so this packet is a fresh press
      pkt(9'd0, 9'd0, 1'b1, 1'b0);
      checks++;
      if (m_req !== 1'b1 || row_rd_en !== 1'b1 || row_addr !== 5'(e_row)) begin
         errors++; $display("FAIL rst_mid_idle: rd=%b addr=%0d want rd=1 addr=%0d", row_rd_en, row_addr, e_row);
      end
      w = apply(ref_grid[e_row], e_col, e_clr);
      repeat (4) @(negedge clk);
      checks++;
      if (mem[e_row] !== w) begin
         errors++; $display("FAIL rst_mid_edit: row%0d=%h want %h", e_row, mem[e_row], w);
      end
      ref_grid[e_row] = w;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; mouse_valid = 1'b0; dx = '0; dy = '0; btn_left = 1'b0; btn_right = 1'b0;
      @(negedge clk);
      test_reset();
      test_clamp();
      test_toggle();
      test_priority();
      test_busy_drop();
      test_random();
      test_reset_mid_edit();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
